vga_timing: RTL and testbench



---
 rtl/vga_timing.sv | 63 ++++++
 tb/tb_vga_timing.sv | 106 ++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters with sync, active-video and line/frame strobes
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_pulse,
  output logic       frame_pulse
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // 11-bit bounds so a 1024-wide total cannot wrap the comparisons
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [10:0] V_FLAST = 11'(V_ACTIVE - 1);
  logic [9:0] h, v;
  logic [10:0] hw, vw;
  logic h_end, v_end, in_hs, in_vs;
  assign hw    = {1'b0, h};
  assign vw    = {1'b0, v};
  assign h_end = hw == H_LAST;
  assign v_end = vw == V_LAST;
  assign in_hs = hw >= HS_BEG && hw < HS_END;
  assign in_vs = vw >= VS_BEG && vw < VS_END;
  always_ff @(posedge clk) begin
    if (!nRst) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      h <= h_end ? '0 : h + 10'd1;
      if (h_end) v <= v_end ? '0 : v + 10'd1;
    end
  end
  always_comb begin
    x           = h;
    y           = v;
    display_on  = hw < H_ACT && vw < V_ACT;
    hsync       = in_hs ? SYNC_POL : ~SYNC_POL;
    vsync       = in_vs ? SYNC_POL : ~SYNC_POL;
    line_pulse  = pix_en && h_end;
    frame_pulse = pix_en && h_end && vw == V_FLAST;
  end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboarded check of a default 640x480 instance and a tiny SYNC_POL=1 instance
module tb_vga_timing;
  typedef struct packed {
    logic [9:0] x, y;
    logic hs, vs, de, lp, fp;
  } out_t;
  logic clk = 0, nRst = 0, pix_en = 0;
  logic d_hs, d_vs, d_de, d_lp, d_fp, s_hs, s_vs, s_de, s_lp, s_fp;
  logic [9:0] d_x, d_y, s_x, s_y;
  int errors = 0, checks = 0;
  int mh = 0, mv = 0, sh = 0, sv = 0, cyc_n = 0, sfp_cnt = 0, first_lp = -1;
  out_t qd[$], qs[$];
  always #5 clk = ~clk;
  vga_timing u_d (.clk(clk), .nRst(nRst), .pix_en(pix_en), .hsync(d_hs), .vsync(d_vs),
    .display_on(d_de), .x(d_x), .y(d_y), .line_pulse(d_lp), .frame_pulse(d_fp));
  vga_timing #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)) u_s (.clk(clk), .nRst(nRst), .pix_en(pix_en),
    .hsync(s_hs), .vsync(s_vs), .display_on(s_de), .x(s_x), .y(s_y), .line_pulse(s_lp),
    .frame_pulse(s_fp));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask
  function automatic out_t model(input int h, input int v, input logic p, input int ha, input int hf,
      input int hs, input int hb, input int va, input int vf, input int vs, input int vb,
      input logic pol);
    out_t o;
    o.x  = 10'(h);
    o.y  = 10'(v);
    o.de = h < ha && v < va;
    o.hs = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
    o.vs = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
    o.lp = p && h == ha + hf + hs + hb - 1;
    o.fp = o.lp && v == va - 1;
    return o;
  endfunction
  task automatic step(inout int h, inout int v, input int ht, input int vt, input logic r,
      input logic p);
    if (!r) begin
      h = 0;
      v = 0;
    end else if (p) begin
      if (h == ht - 1) begin
        h = 0;
        v = (v == vt - 1) ? 0 : v + 1;
      end else h = h + 1;
    end
  endtask
  task automatic cyc(input logic r, input logic p);
    out_t e;
    nRst   = r;
    pix_en = p;
    qd.push_back(model(mh, mv, p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    qs.push_back(model(sh, sv, p, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1));
    @(negedge clk);
    e = qd.pop_front();
    chk("d_x", d_x, e.x);   chk("d_y", d_y, e.y);   chk("d_hs", d_hs, e.hs);
    chk("d_vs", d_vs, e.vs); chk("d_de", d_de, e.de); chk("d_lp", d_lp, e.lp);
    chk("d_fp", d_fp, e.fp);
    e = qs.pop_front();
    chk("s_x", s_x, e.x);   chk("s_y", s_y, e.y);   chk("s_hs", s_hs, e.hs);
    chk("s_vs", s_vs, e.vs); chk("s_de", s_de, e.de); chk("s_lp", s_lp, e.lp);
    chk("s_fp", s_fp, e.fp);
    if (s_fp) sfp_cnt++;
    if (d_lp && first_lp < 0) first_lp = cyc_n;
    @(posedge clk);
    step(mh, mv, 800, 525, r, p);
    step(sh, sv, 15, 8, r, p);
    cyc_n++;
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc(0, 1);
    chk("rst_d_hs", d_hs, 1); chk("rst_d_vs", d_vs, 1); chk("rst_d_de", d_de, 1);
    chk("rst_s_hs", s_hs, 0); chk("rst_s_vs", s_vs, 0); chk("rst_d_lp", d_lp, 0);
    for (int i = 0; i < 1000; i++) cyc(1, 1);
    for (int i = 0; i < 3200; i++) cyc(1, 1'(i % 2 == 0));
    for (int i = 0; i < 1000 && mh != 799; i++) cyc(1, 1);
    chk("reach_x799", d_x, 799);
    for (int i = 0; i < 50; i++) cyc(1, 0);
    cyc(1, 1);
    for (int i = 0; i < 1000 && mh != 300; i++) cyc(1, 1);
    chk("reach_x300", d_x, 300);
    cyc(0, 1);
    chk("mid_rst_x", d_x, 0); chk("mid_rst_y", d_y, 0); chk("mid_rst_hs", d_hs, 1);
    chk("mid_rst_vs", d_vs, 1); chk("mid_rst_de", d_de, 1);
    first_lp = -1;
    cyc_n = 0;
    for (int i = 0; i < 801; i++) cyc(1, 1);
    chk("lp_after_rst", first_lp, 799);
    for (int i = 0; i < 200 && !(sh == 14 && sv == 3); i++) cyc(1, 1);
    chk("reach_s_x", s_x, 14); chk("reach_s_y", s_y, 3);
    for (int i = 0; i < 50; i++) cyc(1, 0);
    cyc(1, 1);
    sfp_cnt = 0;
    for (int i = 0; i < 360; i++) cyc(1, 1);
    chk("s_frames", sfp_cnt, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
